// File: rtl/fivebit_serial_subtractor.sv
// fivebit_serial_subtractor
//   Bit-serial two's-complement subtractor: Diff = A - B - Bin, one bit per
//   clock, LSB first, through a single full-subtractor cell and a registered
//   borrow. Controlled by a start/busy/done handshake.
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous reset, active low
//   start  : request, sampled only in IDLE
//   A, B   : minuend / subtrahend, captured on an accepted start
//   Bin    : borrow-in, captured on an accepted start
//   busy   : high while the serial loop runs (CALC)
//   done   : one-cycle pulse when Diff/Bout/Ovf are valid
//   Diff   : (A - B - Bin) mod 2^WIDTH
//   Bout   : borrow-out, 1 iff A < B + Bin (unsigned)
//   Ovf    : signed overflow of the subtraction
module fivebit_serial_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] areg, breg, dreg;
  logic [CW-1:0]    cnt;
  logic             br, amsb, bmsb, ovf;
  logic             a, b, d, br_nx, last;

  // Full-subtractor cell on the current operand LSBs.
  always_comb begin
    a     = areg[0];
    b     = breg[0];
    d     = a ^ b ^ br;
    br_nx = (~a & b) | (~(a ^ b) & br);
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      areg <= '0;
      breg <= '0;
      dreg <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      amsb <= 1'b0;
      bmsb <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          areg <= A;
          breg <= B;
          br   <= Bin;
          // MSBs kept aside: the operand registers are shifted out by the end.
          amsb <= A[WIDTH-1];
          bmsb <= B[WIDTH-1];
          cnt  <= '0;
          ovf  <= 1'b0;
        end
        CALC: begin
          areg <= areg >> 1;
          breg <= breg >> 1;
          dreg <= {d, dreg[WIDTH-1:1]};
          br   <= br_nx;
          cnt  <= cnt + CW'(1);
          // On the last bit, d is the result MSB, so overflow is settled here
          // and is already valid when done rises.
          if (last) ovf <= (amsb != bmsb) && (d != amsb);
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from flops: no input-to-output combinational path.
  assign busy = (state == CALC);
  assign done = (state == DONE);
  assign Diff = dreg;
  assign Bout = br;
  assign Ovf  = ovf;

endmodule

// File: tb/tb_fivebit_serial_subtractor.sv
module tb_fivebit_serial_subtractor;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n, start, Bin;
  logic [W-1:0] A, B;
  logic         busy, done, Bout, Ovf;
  logic [W-1:0] Diff;

  int vectors = 0;
  int miscompares = 0;

  fivebit_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input int a, input int b, input int bin,
                       output int diff, output int bout, output int ovf);
    int sa, sb, r;
    diff = (a - b - bin) & ((1 << W) - 1);
    bout = (a < b + bin) ? 1 : 0;
    sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb   = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    r    = sa - sb - bin;
    ovf  = (r < -(1 << (W - 1)) || r > (1 << (W - 1)) - 1) ? 1 : 0;
  endtask

  // One operation. Inputs change on negedge, outputs sampled on negedge.
  // noise=1 re-asserts start with A=B=1 during CALC and during DONE.
  task automatic run_op(input string tag, input int a, input int b, input int bin,
                        input bit noise);
    int ed, eb, eo, k, busy_cnt, extra;
    model(a, b, bin, ed, eb, eo);
    @(negedge clk);
    A = W'(a); B = W'(b); Bin = bin[0]; start = 1'b1;
    @(negedge clk);                       // start accepted at the edge just passed
    start = 1'b0;
    k = 0; busy_cnt = 0;
    while (!done && k < 20) begin
      if (busy) busy_cnt++;
      if (noise && k == 2) begin start = 1'b1; A = 1; B = 1; Bin = 1'b0; end
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, k, W);
    chk({tag, ".busycyc"}, busy_cnt, W);
    chk({tag, ".busy_in_done"}, int'(busy), 0);
    chk({tag, ".Diff"}, int'(Diff), ed);
    chk({tag, ".Bout"}, int'(Bout), eb);
    chk({tag, ".Ovf"}, int'(Ovf), eo);
    if (noise) start = 1'b1;              // held through DONE: must be refused
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".done_pulse"}, int'(done), 0);
    extra = 0;
    for (int i = 0; i < (noise ? 10 : 1); i++) begin
      if (done || busy) extra++;
      @(negedge clk);
    end
    chk({tag, ".no_extra"}, extra, 0);
    chk({tag, ".hold_Diff"}, int'(Diff), ed);
    chk({tag, ".hold_Bout"}, int'(Bout), eb);
    chk({tag, ".hold_Ovf"}, int'(Ovf), eo);
  endtask

  initial begin
    int extra;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.Diff", int'(Diff), 0);
    chk("rst.Bout", int'(Bout), 0);
    chk("rst.Ovf",  int'(Ovf), 0);
    rst_n = 1'b1;

    run_op("t1_13m6",     13,  6, 0, 1'b0);
    run_op("t2_6m13",      6, 13, 0, 1'b0);
    run_op("t3_ovf",      15, 16, 0, 1'b0);
    run_op("t4_10m3b",    10,  3, 1, 1'b0);
    run_op("t4_0m0b",      0,  0, 1, 1'b0);
    run_op("eq",          21, 21, 0, 1'b0);
    run_op("negovf",      16,  1, 0, 1'b0);
    run_op("t5_ignore",    9, 20, 1, 1'b1);

    // Reset mid-operation: abandon, no done pulse, then a clean restart.
    @(negedge clk);
    A = 5'd27; B = 5'd4; Bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);            // bits 0 and 1 processed
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6.busy", int'(busy), 0);
    chk("t6.done", int'(done), 0);
    chk("t6.Diff", int'(Diff), 0);
    chk("t6.Bout", int'(Bout), 0);
    chk("t6.Ovf",  int'(Ovf), 0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) extra++;
      @(negedge clk);
    end
    chk("t6.no_done", extra, 0);
    run_op("t6_restart", 27, 4, 1, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op("rand", int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 1)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
